// File: rtl/instr_fetch_queue_if.sv
// Fetch-unit bus: redirect input, instruction-memory request/response channel,
// and the decode-side instruction handshake.
interface instr_fetch_queue_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;

   modport master (
      input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
      output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc
   );
   modport slave (
      output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
      input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc
   );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues credit-limited sequential
// reads, queues in-order responses with their PC, and flushes on redirect.
module instr_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                reset,
   instr_fetch_queue_if.master bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } entry_t;

   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_rsp_pc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_discard;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   entry_t        r_mem [DEPTH];

   logic [CW:0]   w_inflight;
   logic          w_credit;
   logic          w_redir;
   logic [31:0]   w_redir_pc;
   logic          w_fire;
   logic          w_push;
   logic          w_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_redir    = bus.redirect_valid;
   assign w_redir_pc = bus.redirect_pc & ~32'h3;
   assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_count};
   // Every issued request already owns a queue slot, so responses never stall.
   assign w_credit   = w_inflight < (CW+1)'(DEPTH);

   assign bus.mem_req_valid = w_credit && !w_redir;
   assign bus.mem_req_addr  = r_fetch_pc;
   assign bus.inst_valid    = (r_count != '0) && !w_redir;
   assign bus.inst_pc       = r_mem[r_rd_ptr].pc;
   assign bus.inst_data     = r_mem[r_rd_ptr].data;

   assign w_fire = bus.mem_req_valid && bus.mem_req_ready;
   assign w_pop  = bus.inst_valid && bus.inst_ready;
   assign w_push = bus.mem_rsp_valid && (r_discard == '0) && !w_redir;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_pc    <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_count       <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      end else begin
         r_outstanding <= r_outstanding + CW'(w_fire) - CW'(bus.mem_rsp_valid);
         if (w_redir) begin
            r_fetch_pc <= w_redir_pc;
            r_rsp_pc   <= w_redir_pc;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            // All in-flight responses are stale now, including ones already marked,
            // so the drop count is simply what remains outstanding.
            r_discard  <= r_outstanding - CW'(bus.mem_rsp_valid);
         end else begin
            if (w_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
            if (bus.mem_rsp_valid && (r_discard != '0)) r_discard <= r_discard - CW'(1);
            if (w_push) begin
               r_mem[r_wr_ptr] <= '{pc: r_rsp_pc, data: bus.mem_rsp_data};
               r_wr_ptr        <= ptr_inc(r_wr_ptr);
               r_rsp_pc        <= r_rsp_pc + 32'd4;
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: latency-configurable memory model plus an
// expected-instruction scoreboard checked on every decode pop.
module tb_instr_fetch_queue;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   instr_fetch_queue_if bus();

   instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   typedef struct packed { logic [31:0] pc; logic [31:0] data; } exp_t;
   typedef struct { logic [31:0] addr; int due; } pend_t;

   exp_t        exp_q[$];
   pend_t       pend_q[$];
   logic [31:0] fire_log[$];
   logic [31:0] pop_log[$];
   logic        iv_log[$];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   lat = 1;
   int   n_fire = 0;
   int   n_pop = 0;
   logic rdy_inst = 1'b1;
   logic rdy_mem = 1'b1;
   logic s_rqv, s_iv, s_fire, s_pop, s_rsp;
   logic [31:0] s_addr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[31:16] ^ 16'h5A5A, a[15:0] ^ 16'hBEEF};
   endfunction

   // One cycle: drive inputs at negedge, sample just after, update models, advance.
   task automatic step();
      exp_t e;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_data  = mem_word(pend_q[0].addr);
      end else begin
         bus.mem_rsp_valid = 1'b0;
         bus.mem_rsp_data  = 32'h0;
      end
      bus.inst_ready    = rdy_inst;
      bus.mem_req_ready = rdy_mem;
      #1;
      s_rqv  = bus.mem_req_valid;
      s_addr = bus.mem_req_addr;
      s_iv   = bus.inst_valid;
      s_rsp  = bus.mem_rsp_valid;
      s_fire = bus.mem_req_valid && bus.mem_req_ready;
      s_pop  = bus.inst_valid && bus.inst_ready;
      iv_log.push_back(s_iv);
      if (bus.redirect_valid) begin
         chk("req_blocked_on_redirect", 32'(bus.mem_req_valid), 32'd0);
         chk("iv_blocked_on_redirect", 32'(bus.inst_valid), 32'd0);
      end
      if (s_pop) begin
         n_pop++;
         if (exp_q.size() == 0) chk("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
         else begin
            e = exp_q.pop_front();
            chk("inst_pc", bus.inst_pc, e.pc);
            chk("inst_data", bus.inst_data, e.data);
            pop_log.push_back(bus.inst_pc);
         end
      end
      if (bus.redirect_valid) exp_q.delete();
      else if (s_fire) exp_q.push_back('{pc: s_addr, data: mem_word(s_addr)});
      if (bus.mem_rsp_valid) void'(pend_q.pop_front());
      if (s_fire) begin
         pend_q.push_back('{addr: s_addr, due: cyc + lat});
         fire_log.push_back(s_addr);
         n_fire++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_logs();
      fire_log.delete(); pop_log.delete(); iv_log.delete();
      n_fire = 0; n_pop = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.mem_rsp_valid  = 1'b0;
      pend_q.delete(); exp_q.delete();
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      cyc = 0;
      clear_logs();
   endtask

   task automatic redirect(input logic [31:0] pc);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = pc;
      step();
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
   endtask

   task automatic drain(input string tag);
      int n;
      rdy_mem = 1'b0; rdy_inst = 1'b1; n = 0;
      while (exp_q.size() != 0 && n < 40) begin step(); n++; end
      chk(tag, 32'(exp_q.size()), 32'd0);
      rdy_mem = 1'b1;
   endtask

   initial begin
      bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
      bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data = 32'h0; bus.inst_ready = 1'b0;
      #2;
      chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("rst_req_addr", bus.mem_req_addr, 32'h0);
      chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      chk("rst_inst_data", bus.inst_data, 32'h0);
      chk("rst_inst_pc", bus.inst_pc, 32'h0);

      // Streaming with a 1-cycle memory
      lat = 1; rdy_inst = 1'b1; rdy_mem = 1'b1;
      do_reset();
      steps(8);
      for (int i = 0; i < 4; i++) chk("stream_addr", fire_log[i], 32'(4 * i));
      chk("iv_c0", 32'(iv_log[0]), 32'd0);
      chk("iv_c1", 32'(iv_log[1]), 32'd0);
      chk("iv_c2", 32'(iv_log[2]), 32'd1);
      for (int i = 0; i < 3; i++) chk("stream_pc", pop_log[i], 32'(4 * i));
      chk("stream_rate", 32'(n_pop), 32'd6);

      // Credit limit with decode stalled
      lat = 1; rdy_inst = 1'b0;
      do_reset();
      steps(10);
      chk("credit_fires", 32'(n_fire), 32'(DEPTH));
      chk("credit_req_low", 32'(s_rqv), 32'd0);
      rdy_inst = 1'b1;
      steps(12);
      chk("credit_resume", 32'(n_fire > DEPTH), 32'd1);
      drain("credit_drain");
      chk("credit_no_loss", 32'(n_pop), 32'(n_fire));

      // Redirect with three stale responses in flight
      lat = 3; rdy_inst = 1'b1;
      do_reset();
      steps(3);
      chk("inflight_fires", 32'(n_fire), 32'd3);
      redirect(32'h0000_0103);
      step();
      chk("redir_req_valid", 32'(s_rqv), 32'd1);
      chk("redir_req_addr", s_addr, 32'h0000_0100);
      pop_log.delete();
      steps(12);
      chk("redir_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hFFFF_FFFF, 32'h0000_0100);
      drain("redir_drain");

      // Redirect colliding with a response and a pending pop
      lat = 1; rdy_inst = 1'b1;
      do_reset();
      steps(6);
      chk("collide_pre_iv", 32'(s_iv), 32'd1);
      redirect(32'h0000_0200);
      chk("collide_rsp", 32'(s_rsp), 32'd1);
      chk("collide_no_pop", 32'(s_pop), 32'd0);
      step();
      chk("collide_empty_next", 32'(s_iv), 32'd0);
      chk("collide_new_addr", s_addr, 32'h0000_0200);
      steps(4);

      // Address wrap
      redirect(32'hFFFF_FFF8);
      clear_logs();
      steps(10);
      chk("wrap_a0", fire_log[0], 32'hFFFF_FFF8);
      chk("wrap_a1", fire_log[1], 32'hFFFF_FFFC);
      chk("wrap_a2", fire_log[2], 32'h0000_0000);
      chk("wrap_p0", pop_log[0], 32'hFFFF_FFF8);
      chk("wrap_p1", pop_log[1], 32'hFFFF_FFFC);
      chk("wrap_p2", pop_log[2], 32'h0000_0000);
      drain("wrap_drain");

      // Asynchronous reset mid-burst
      lat = 3; rdy_inst = 1'b1;
      do_reset();
      steps(2);
      chk("mid_addr_pre", bus.mem_req_addr, 32'h0000_0008);
      reset = 1'b1;
      #1;
      chk("async_req_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("async_req_addr", bus.mem_req_addr, 32'h0);
      chk("async_inst_valid", 32'(bus.inst_valid), 32'd0);
      chk("async_inst_pc", bus.inst_pc, 32'h0);
      chk("async_inst_data", bus.inst_data, 32'h0);
      lat = 1; rdy_inst = 1'b0;
      do_reset();
      steps(8);
      chk("post_rst_addr0", fire_log[0], 32'h0);
      chk("post_rst_credit", 32'(n_fire), 32'(DEPTH));
      drain("post_rst_drain");
      chk("post_rst_pc0", pop_log[0], 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
